cla_seq_adder: RTL and testbench



---
 rtl/cla_pkg.sv | 18 +
 rtl/cla_slice.sv | 44 ++++
 rtl/cla_seq_adder.sv | 121 ++++++++++++
 tb/tb_cla_seq_adder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and constants for the sequential carry-lookahead adder.
package cla_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    // An index counter needs at least one bit, even when only one slice exists.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cla_slice.sv
// Purely combinational CHUNK-bit carry-lookahead adder slice.
module cla_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK-1:0] p;
    logic [CHUNK-1:0] g;
    logic [CHUNK:0]   c;
    logic             acc;
    logic             prod;

    assign p = x ^ y;
    assign g = x & y;

    // Each carry is the flat sum of products g[j] & p[i..j+1], plus the
    // all-propagate term with cin, so no carry depends on a previous one.
    always_comb begin
        // NOTE: every variable assigned here gets a value on every pass first,
        // otherwise a latch is inferred.
        c    = '0;
        acc  = 1'b0;
        prod = 1'b1;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            acc  = 1'b0;
            prod = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc  = acc | (prod & g[j]);
                prod = prod & p[j];
            end
            c[i+1] = acc | (prod & cin);
        end
    end

    assign s    = p ^ c[CHUNK-1:0];
    assign cout = c[CHUNK];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle add/subtract unit: one CHUNK-bit lookahead slice per clock,
// least-significant slice first, with a registered carry between slices.
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int              NCHUNK   = WIDTH / CHUNK;
    localparam int              IDXW     = clog2_min1(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [IDXW-1:0]  idx_q;
    logic             carry_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             cout_q;
    logic             ovf_q;

    int               base_d;
    logic [CHUNK-1:0] x_d;
    logic [CHUNK-1:0] y_d;
    logic [CHUNK-1:0] s_d;
    logic             co_d;

    assign base_d = int'(idx_q) * CHUNK;
    assign x_d    = a_q[base_d +: CHUNK];
    assign y_d    = b_q[base_d +: CHUNK];

    cla_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .x    (x_d),
        .y    (y_d),
        .cin  (carry_q),
        .s    (s_d),
        .cout (co_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // right-hand side reads the value from before this edge.
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        // Subtraction is a + ~b + 1; the +1 enters as the first carry.
                        a_q        <= a;
                        b_q        <= sub ? ~b : b;
                        carry_q    <= sub;
                        idx_q      <= '0;
                        a_msb_q    <= a[WIDTH-1];
                        b_msb_q    <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    sum_q[base_d +: CHUNK] <= s_d;
                    carry_q                <= co_d;
                    if (idx_q == LAST_IDX) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        cout_q      <= co_d;
                        ovf_q       <= (a_msb_q == b_msb_q) && (s_d[CHUNK-1] != a_msb_q);
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed and model-checked bench for cla_seq_adder in the 16/4 and 8/8 builds.
module tb_cla_seq_adder;

    logic clk = 1'b0;
    logic rst;

    logic        in_valid16, in_ready16, sub16, out_valid16, out_ready16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;
    logic        in_valid8, in_ready8, sub8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cla_seq_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .sub       (sub16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .sum       (sum16),
        .cout      (cout16),
        .ovf       (ovf16)
    );

    cla_seq_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .sub       (sub8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .cout      (cout8),
        .ovf       (ovf8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference built from signed/unsigned integer arithmetic.
    task automatic model(input int w, input int av, input int bv, input bit s,
                         output int es, output bit ec, output bit ev);
        int full, sa, sb, r;
        int maxu = (1 << w) - 1;
        full = s ? (av - bv) : (av + bv);
        es   = full & maxu;
        ec   = s ? (av >= bv) : (full > maxu);
        sa   = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
        sb   = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
        r    = s ? (sa - sb) : (sa + sb);
        ev   = (r > (1 << (w - 1)) - 1) || (r < -(1 << (w - 1)));
    endtask

    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                        input logic [15:0] es, input logic ec, input logic ev,
                        input int hold, input string tag);
        int n = 0;
        while (!in_ready16 && n < 50) begin @(negedge clk); n++; end
        a16 = av; b16 = bv; sub16 = sv; in_valid16 = 1'b1;
        @(negedge clk);
        in_valid16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); sub16 = ~sv;
        n = 0;
        while (!out_valid16 && n < 50) begin @(negedge clk); n++; end
        check({tag, " latency"}, n, 4);
        check({tag, " sum"}, sum16, es);
        check({tag, " cout"}, cout16, ec);
        check({tag, " ovf"}, ovf16, ev);
        for (int h = 0; h < hold; h++) begin
            a16 = 16'($urandom); b16 = 16'($urandom); in_valid16 = h[0];
            @(negedge clk);
            check({tag, " hold valid"}, out_valid16, 1'b1);
            check({tag, " hold ready"}, in_ready16, 1'b0);
            check({tag, " hold result"}, {ovf16, cout16, sum16}, {ev, ec, es});
        end
        in_valid16 = 1'b0;
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;
        check({tag, " release"}, {out_valid16, in_ready16}, 2'b01);
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                       input logic [7:0] es, input logic ec, input logic ev, input string tag);
        int n = 0;
        while (!in_ready8 && n < 50) begin @(negedge clk); n++; end
        a8 = av; b8 = bv; sub8 = sv; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        n = 0;
        while (!out_valid8 && n < 50) begin @(negedge clk); n++; end
        check({tag, " latency"}, n, 1);
        check({tag, " result"}, {ovf8, cout8, sum8}, {ev, ec, es});
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        check({tag, " release"}, {out_valid8, in_ready8}, 2'b01);
    endtask

    initial begin
        int es;
        bit ec, ev;
        logic [15:0] ra, rb;
        logic        rs;
        int n;

        rst = 1'b1;
        in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0;
        in_valid8  = 1'b0; out_ready8  = 1'b0; a8  = '0; b8  = '0; sub8  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset16 outputs", {in_ready16, out_valid16, cout16, ovf16, sum16}, {4'b1000, 16'h0000});
        check("reset8 outputs", {in_ready8, out_valid8, cout8, ovf8, sum8}, {4'b1000, 8'h00});
        rst = 1'b0;
        @(negedge clk);
        check("idle16 after reset", {in_ready16, out_valid16}, 2'b10);

        op16(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 0, "add_carry_chain");
        op16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, "add_wrap");
        op16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, "add_ovf");
        op16(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0, "sub_borrow");
        op16(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0, "sub_ovf");
        op16(16'h1357, 16'h2468, 1'b0, 16'h37BF, 1'b0, 1'b0, 5, "hold_done");

        // Reset pulse during the second compute cycle.
        a16 = 16'h4000; b16 = 16'h4000; sub16 = 1'b0; in_valid16 = 1'b1;
        @(negedge clk);
        in_valid16 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset outputs", {in_ready16, out_valid16, cout16, ovf16, sum16}, {4'b1000, 16'h0000});
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid16) n++;
        end
        check("midreset no out_valid", n, 0);
        op16(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 0, "after_reset");

        op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "w8_add_ovf");
        op8(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, "w8_sub_borrow");

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            model(16, int'(ra), int'(rb), rs, es, ec, ev);
            op16(ra, rb, rs, 16'(es), ec, ev, 0, "rand16");
        end
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom_range(0, 255)); rb = 16'($urandom_range(0, 255)); rs = 1'($urandom);
            model(8, int'(ra), int'(rb), rs, es, ec, ev);
            op8(ra[7:0], rb[7:0], rs, 8'(es), ec, ev, "rand8");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
